// File: rtl/lic_bus_ctrl.sv
// Bus responder between the core's 32-bit peripheral port and the LIC timer registers.
// Each access runs IDLE -> ACCESS -> RESP with a single outstanding request.
module lic_bus_ctrl #(
  parameter int unsigned   XLEN          = 64,
  parameter int unsigned   AW            = 16,
  parameter logic [AW-1:0] MTIMECMP_BASE = AW'(16'h4000),
  parameter logic [AW-1:0] MTIME_BASE    = AW'(16'hBFF8)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [AW-1:0]   req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  input  logic [XLEN-1:0] lic_mtime_read,
  output logic [XLEN-1:0] lic_mtime_write,
  output logic            lic_mtime_write_ena,
  input  logic [XLEN-1:0] lic_mtimecmp_read,
  output logic [XLEN-1:0] lic_mtimecmp_write,
  output logic            lic_mtimecmp_write_ena
);

  localparam int unsigned HW = 32;
  localparam logic [AW-1:0] MTIMECMP_HI = MTIMECMP_BASE + AW'(4);
  localparam logic [AW-1:0] MTIME_HI    = MTIME_BASE + AW'(4);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [HW-1:0]     wdata_q, wdata_d;
  logic [HW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [HW-1:0]     shadow_hi_q, shadow_hi_d;
  logic              shadow_vld_q, shadow_vld_d;

  logic sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi, aligned, hit;

  // Full-address decode of the registered request
  always_comb begin
    aligned     = (addr_q[1:0] == 2'b00);
    sel_cmp_lo  = aligned && (addr_q == MTIMECMP_BASE);
    sel_cmp_hi  = aligned && (addr_q == MTIMECMP_HI);
    sel_time_lo = aligned && (addr_q == MTIME_BASE);
    sel_time_hi = aligned && (addr_q == MTIME_HI);
    hit         = sel_cmp_lo || sel_cmp_hi || sel_time_lo || sel_time_hi;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      shadow_hi_q  <= '0;
      shadow_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      shadow_hi_q  <= shadow_hi_d;
      shadow_vld_q <= shadow_vld_d;
    end
  end

  // Next state, response capture and LIC write strobes
  always_comb begin
    state_d                = state_q;
    wr_d                   = wr_q;
    addr_d                 = addr_q;
    wdata_d                = wdata_q;
    rdata_d                = rdata_q;
    err_d                  = err_q;
    shadow_hi_d            = shadow_hi_q;
    shadow_vld_d           = shadow_vld_q;
    req_ready              = 1'b0;
    rsp_valid              = 1'b0;
    lic_mtime_write        = '0;
    lic_mtime_write_ena    = 1'b0;
    lic_mtimecmp_write     = '0;
    lic_mtimecmp_write_ena = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        state_d = S_RESP;
        err_d   = !hit;
        rdata_d = '0;
        if (hit && wr_q) begin
          // The untouched half is taken from the LIC value seen this cycle
          if (sel_cmp_lo) begin
            lic_mtimecmp_write_ena = 1'b1;
            lic_mtimecmp_write     = {lic_mtimecmp_read[XLEN-1:HW], wdata_q};
          end else if (sel_cmp_hi) begin
            lic_mtimecmp_write_ena = 1'b1;
            lic_mtimecmp_write     = {wdata_q, lic_mtimecmp_read[HW-1:0]};
          end else if (sel_time_lo) begin
            lic_mtime_write_ena = 1'b1;
            lic_mtime_write     = {lic_mtime_read[XLEN-1:HW], wdata_q};
            shadow_vld_d        = 1'b0;
          end else begin
            lic_mtime_write_ena = 1'b1;
            lic_mtime_write     = {wdata_q, lic_mtime_read[HW-1:0]};
            shadow_vld_d        = 1'b0;
          end
        end else if (hit) begin
          if (sel_cmp_lo) begin
            rdata_d = lic_mtimecmp_read[HW-1:0];
          end else if (sel_cmp_hi) begin
            rdata_d = lic_mtimecmp_read[XLEN-1:HW];
          end else if (sel_time_lo) begin
            rdata_d      = lic_mtime_read[HW-1:0];
            shadow_hi_d  = lic_mtime_read[XLEN-1:HW];
            shadow_vld_d = 1'b1;
          end else begin
            rdata_d      = shadow_vld_q ? shadow_hi_q : lic_mtime_read[XLEN-1:HW];
            shadow_vld_d = 1'b0;
          end
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
